// File: rtl/rf_arb_pkg.sv
// Shared types and helpers for the register-file port arbiter.
package rf_arb_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int unsigned NRD = 2;
    localparam int unsigned NWR = 1;

    // idx is the scan offset of the first grant relative to ptr; result is the slot after it.
    function automatic int unsigned rr_next(input int unsigned ptr,
                                            input int unsigned idx,
                                            input int unsigned nreq);
        int unsigned s;
        s = ptr + idx + 1;
        if (s >= nreq) s = s - nreq;
        return s;
    endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// Register storage: two asynchronous read ports, one synchronous write port, no reset.
module regfile_2r1w #(
    parameter int unsigned AW = 6,
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr0,
    input  logic [AW-1:0] raddr1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata0 = mem[raddr0];
    assign rdata1 = mem[raddr1];

endmodule

// File: rtl/regfile_port_arbiter.sv
// Round-robin arbiter sharing a 2R1W register file among NREQ requesters, with power-up init sweep.
// Define RF_ARB_BYPASS_EN to forward a same-cycle write to a granted read of the same address.
module regfile_port_arbiter
    import rf_arb_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned AW   = 6,
    parameter int unsigned DW   = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ-1:0]   req_we,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [NREQ*DW-1:0] rsp_data,
    output logic              init_done
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t            state, state_nxt;
    logic [AW-1:0]     init_cnt;
    logic [PW-1:0]     rr_ptr;

    logic [NREQ-1:0]   gnt;
    logic [NRD-1:0]    rd_hit;
    logic [PW-1:0]     rd_idx [NRD];
    logic              wr_hit;
    logic [PW-1:0]     wr_idx;
    logic              any_gnt;
    int unsigned       first_off;

    logic              rf_we;
    logic [AW-1:0]     rf_waddr;
    logic [DW-1:0]     rf_wdata;
    logic [AW-1:0]     rf_raddr [NRD];
    logic [DW-1:0]     rf_rdata [NRD];
    logic [DW-1:0]     rd_data  [NRD];
    logic [NREQ*DW-1:0] rsp_nxt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= INIT;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (state == INIT && init_cnt == '1) state_nxt = RUN;
    end

    assign init_done = (state == RUN);

    // Scan from rr_ptr; read ports fill in scan order, the write port goes to the first writer.
    always_comb begin
        int unsigned   nrd;
        int unsigned   nwr;
        int unsigned   s;
        logic [PW-1:0] idx;
        gnt       = '0;
        rd_hit    = '0;
        rd_idx    = '{default: '0};
        wr_hit    = 1'b0;
        wr_idx    = '0;
        any_gnt   = 1'b0;
        first_off = 0;
        nrd       = 0;
        nwr       = 0;
        s         = 0;
        idx       = '0;
        if (state == RUN) begin
            for (int unsigned k = 0; k < NREQ; k++) begin
                s = 32'(rr_ptr) + k;
                if (s >= NREQ) s = s - NREQ;
                idx = PW'(s);
                if (req_valid[idx]) begin
                    if (req_we[idx]) begin
                        if (nwr < NWR) begin
                            gnt[idx] = 1'b1;
                            wr_hit   = 1'b1;
                            wr_idx   = idx;
                            nwr      = nwr + 1;
                        end
                    end else if (nrd < NRD) begin
                        gnt[idx] = 1'b1;
                        if (nrd == 0) begin
                            rd_hit[0] = 1'b1;
                            rd_idx[0] = idx;
                        end else begin
                            rd_hit[1] = 1'b1;
                            rd_idx[1] = idx;
                        end
                        nrd = nrd + 1;
                    end
                    if (gnt[idx] && !any_gnt) begin
                        any_gnt   = 1'b1;
                        first_off = k;
                    end
                end
            end
        end
    end

    assign req_ready = gnt;

    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        if (state == INIT) begin
            rf_we    = 1'b1;
            rf_waddr = init_cnt;
            rf_wdata = DW'(init_cnt);
        end else if (wr_hit) begin
            rf_we    = 1'b1;
            rf_waddr = req_addr[wr_idx*AW +: AW];
            rf_wdata = req_wdata[wr_idx*DW +: DW];
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        assign rf_raddr[p] = req_addr[rd_idx[p]*AW +: AW];
`ifdef RF_ARB_BYPASS_EN
        assign rd_data[p] = (wr_hit && rf_waddr == rf_raddr[p]) ? rf_wdata : rf_rdata[p];
`else
        assign rd_data[p] = rf_rdata[p];
`endif
    end

    regfile_2r1w #(
        .AW (AW),
        .DW (DW)
    ) u_rf (
        .clk    (clk),
        .we     (rf_we),
        .waddr  (rf_waddr),
        .wdata  (rf_wdata),
        .raddr0 (rf_raddr[0]),
        .raddr1 (rf_raddr[1]),
        .rdata0 (rf_rdata[0]),
        .rdata1 (rf_rdata[1])
    );

    always_comb begin
        rsp_nxt = rsp_data;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                if (req_we[i])
                    rsp_nxt[i*DW +: DW] = req_wdata[i*DW +: DW];
                else if (rd_hit[0] && rd_idx[0] == PW'(i))
                    rsp_nxt[i*DW +: DW] = rd_data[0];
                else if (rd_hit[1] && rd_idx[1] == PW'(i))
                    rsp_nxt[i*DW +: DW] = rd_data[1];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            init_cnt  <= '0;
            rr_ptr    <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
        end else begin
            if (state == INIT) init_cnt <= init_cnt + AW'(1);
            if (any_gnt) rr_ptr <= PW'(rr_next(32'(rr_ptr), first_off, NREQ));
            rsp_valid <= gnt;
            rsp_data  <= rsp_nxt;
        end
    end

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Randomized + directed bench for regfile_port_arbiter against a behavioural round-robin model.
`timescale 1ns/1ps
module tb_regfile_port_arbiter;

    localparam int NREQ  = 4;
    localparam int AW    = 6;
    localparam int DW    = 32;
    localparam int DEPTH = 64;

    logic                 clk = 1'b0;
    logic                 rstn;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_we;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*DW-1:0]   req_wdata;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ-1:0]      rsp_valid;
    logic [NREQ*DW-1:0]   rsp_data;
    logic                 init_done;

    always #5 clk = ~clk;

    regfile_port_arbiter #(
        .NREQ (NREQ),
        .AW   (AW),
        .DW   (DW)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .init_done (init_done)
    );

    int total = 0;
    int bad   = 0;

    // requester-side request table
    logic          v  [NREQ];
    logic          we [NREQ];
    logic [AW-1:0] ad [NREQ];
    logic [DW-1:0] wd [NREQ];
    int            wt [NREQ];

    // reference model state
    logic [DW-1:0] mem [DEPTH];
    int            ptr;
    logic [NREQ-1:0] exp_rv;
    logic [DW-1:0] exp_rd [NREQ];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic drive();
        for (int j = 0; j < NREQ; j++) begin
            req_valid[j]          = v[j];
            req_we[j]             = we[j];
            req_addr[j*AW +: AW]  = ad[j];
            req_wdata[j*DW +: DW] = wd[j];
        end
    endtask

    task automatic clear_reqs();
        for (int j = 0; j < NREQ; j++) begin
            v[j] = 1'b0; we[j] = 1'b0; ad[j] = '0; wd[j] = '0; wt[j] = 0;
        end
    endtask

    task automatic set_req(input int j, input logic w, input int a, input logic [DW-1:0] d);
        v[j] = 1'b1; we[j] = w; ad[j] = AW'(a); wd[j] = d;
    endtask

    // One RUN cycle: present requests, compare against the model, advance the model.
    task automatic run_cycle(input bit keep, output logic [NREQ-1:0] rdy);
        logic [NREQ-1:0] g;
        logic [DW-1:0]   nd [NREQ];
        int nrd, nwr, first, i;
        drive();
        @(negedge clk);
        rdy = req_ready;
        g = '0; nrd = 0; nwr = 0; first = -1;
        for (int k = 0; k < NREQ; k++) begin
            i = (ptr + k) % NREQ;
            if (v[i]) begin
                if (we[i] && nwr < 1) begin g[i] = 1'b1; nwr++; end
                else if (!we[i] && nrd < 2) begin g[i] = 1'b1; nrd++; end
                if (g[i] && first < 0) first = i;
            end
        end
        chk("ready", 32'(rdy), 32'(g));
        chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
        for (int j = 0; j < NREQ; j++)
            chk($sformatf("rsp_data%0d", j), rsp_data[j*DW +: DW], exp_rd[j]);
        for (int j = 0; j < NREQ; j++) begin
            if (v[j]) begin
                if (rdy[j]) begin
                    chk($sformatf("wait_bound%0d", j), 32'(wt[j] <= NREQ-1), 32'd1);
                    wt[j] = 0;
                end else begin
                    wt[j]++;
                end
            end
        end
        for (int j = 0; j < NREQ; j++) begin
            nd[j] = exp_rd[j];
            if (g[j]) begin
                if (we[j]) nd[j] = wd[j];
                else begin
                    nd[j] = mem[ad[j]];
`ifdef RF_ARB_BYPASS_EN
                    for (int m = 0; m < NREQ; m++)
                        if (g[m] && we[m] && ad[m] == ad[j]) nd[j] = wd[m];
`endif
                end
            end
        end
        for (int j = 0; j < NREQ; j++)
            if (g[j] && we[j]) mem[ad[j]] = wd[j];
        if (first >= 0) ptr = (first + 1) % NREQ;
        @(posedge clk);
        #1;
        exp_rv = g;
        for (int j = 0; j < NREQ; j++) begin
            exp_rd[j] = nd[j];
            if (!keep && g[j]) v[j] = 1'b0;
        end
    endtask

    // Assert reset now, check cleared outputs, release and time the init sweep.
    task automatic do_reset_init();
        int n;
        rstn = 1'b0;
        clear_reqs();
        drive();
        #1;
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_init_done", 32'(init_done), 32'd0);
        for (int j = 0; j < NREQ; j++)
            chk($sformatf("rst_rsp_data%0d", j), rsp_data[j*DW +: DW], 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        n = 0;
        while (init_done !== 1'b1 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("init_cycles", 32'(n), 32'd64);
        for (int a = 0; a < DEPTH; a++) mem[a] = DW'(a);
        ptr = 0;
        exp_rv = '0;
        for (int j = 0; j < NREQ; j++) exp_rd[j] = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got time=%0t expected finish before limit", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NREQ-1:0] r;
        rstn = 1'b1;
        clear_reqs();
        drive();
        #2;
        do_reset_init();

        // four simultaneous reads from rr_ptr=0
        for (int j = 0; j < NREQ; j++) set_req(j, 1'b0, j + 1, '0);
        run_cycle(0, r);
        chk("t2_ready0", 32'(r), 32'h3);
        chk("t2_rsp0", rsp_data[0*DW +: DW], 32'd1);
        chk("t2_rsp1", rsp_data[1*DW +: DW], 32'd2);
        run_cycle(0, r);
        chk("t2_ready1", 32'(r), 32'hC);
        chk("t2_rsp2", rsp_data[2*DW +: DW], 32'd3);
        chk("t2_rsp3", rsp_data[3*DW +: DW], 32'd4);

        // two writers contend for the single write port
        set_req(1, 1'b1, 10, 32'hAAAA);
        set_req(2, 1'b1, 11, 32'h5555);
        run_cycle(0, r);
        chk("t3_ready0", 32'(r), 32'h2);
        run_cycle(0, r);
        chk("t3_ready1", 32'(r), 32'h4);
        set_req(1, 1'b0, 10, '0);
        set_req(2, 1'b0, 11, '0);
        run_cycle(0, r);
        chk("t3_ready2", 32'(r), 32'h6);
        chk("t3_rd10", rsp_data[1*DW +: DW], 32'hAAAA);
        chk("t3_rd11", rsp_data[2*DW +: DW], 32'h5555);

        // same-address read and write in one cycle
        set_req(0, 1'b1, 7, 32'h1234);
        set_req(1, 1'b0, 7, '0);
        run_cycle(0, r);
        chk("t4_ready", 32'(r), 32'h3);
`ifdef RF_ARB_BYPASS_EN
        chk("t4_rd7", rsp_data[1*DW +: DW], 32'h1234);
`else
        chk("t4_rd7", rsp_data[1*DW +: DW], 32'd7);
`endif
        chk("t4_wr7", rsp_data[0*DW +: DW], 32'h1234);

        set_req(1, 1'b0, 5, '0);
        run_cycle(0, r);
        chk("t1_rd5", rsp_data[1*DW +: DW], 32'd5);

        // all four keep reading continuously
        for (int c = 0; c < 40; c++) begin
            for (int j = 0; j < NREQ; j++) set_req(j, 1'b0, $urandom_range(0, DEPTH-1), '0);
            run_cycle(1, r);
        end
        clear_reqs();

        // random mixed traffic; idle requesters raise new requests and hold them until granted
        for (int c = 0; c < 1000; c++) begin
            for (int j = 0; j < NREQ; j++) begin
                if (!v[j] && $urandom_range(0, 1) == 1) begin
                    v[j]  = 1'b1;
                    we[j] = ($urandom_range(0, 2) == 0);
                    ad[j] = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7))
                                                        : AW'($urandom_range(0, DEPTH-1));
                    wd[j] = $urandom;
                end
            end
            run_cycle(0, r);
        end
        clear_reqs();

        // reset in the middle of a transfer
        set_req(0, 1'b1, 10, 32'hFF);
        run_cycle(0, r);
        chk("t5_wr_rsp", rsp_data[0*DW +: DW], 32'hFF);
        set_req(0, 1'b1, 12, 32'h33);
        drive();
        @(negedge clk);
        chk("t5_ready_before_rst", 32'(req_ready[0]), 32'd1);
        do_reset_init();
        set_req(2, 1'b0, 10, '0);
        run_cycle(0, r);
        chk("t5_rd10", rsp_data[2*DW +: DW], 32'd10);
        set_req(3, 1'b0, 12, '0);
        run_cycle(0, r);
        chk("t5_rd12", rsp_data[3*DW +: DW], 32'd12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
